// File: rtl/riscv_pkg.sv
// Shared decode types: control record, opcode enum, immediate/ALU selectors
// and the FIFO entry carried from decode to execute.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [6:0] {
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    I_TYPE = 7'b0010011,
    R_TYPE = 7'b0110011,
    JALR   = 7'b1100111,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111
  } opcode_e;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_MULDIV = 2'b11;

  typedef struct packed {
    logic [3:0] reg_w;
    logic [2:0] imm_src;
    logic       alu_src;
    logic [3:0] mem_w;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       pc_update;
    logic       lui;
    logic       auipc;
  } cntrl_sigs_t;

  typedef struct packed {
    cntrl_sigs_t     ctrl;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } dec_entry_t;

endpackage

// File: rtl/decode_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full/empty
// fall out of a pointer compare. DEPTH must be a power of two.
module decode_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  T            mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop && !empty)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only visible once wptr moves past it.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, valid/ready instruction decode stage with output FIFO and a
// saturating illegal-instruction counter. DECODE_M_EXT_EN enables MUL/DIV decode.
module decode_stage #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int FIFO_DEPTH = 2,
  parameter int ILL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output riscv_pkg::cntrl_sigs_t out_ctrl,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [2:0]             out_funct3,
  output logic [6:0]             out_funct7,
  output logic [XLEN-1:0]        out_pc,
  output logic                   out_illegal,
  output logic [ILL_CNT_W-1:0]   ill_count
);

  import riscv_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // ready never depends on the same-cycle valid of the partner.
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        legal;
  logic        shift;
  cntrl_sigs_t ctrl;
  dec_entry_t  dec;
  dec_entry_t  head;
  dec_entry_t  head_view;

  wire [6:0] opcode = in_instr[6:0];
  wire [2:0] f3     = in_instr[14:12];
  wire [6:0] f7     = in_instr[31:25];

  assign in_ready  = !full && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    ctrl  = '0;
    legal = 1'b1;
    shift = (f3 == 3'b001) || (f3 == 3'b101);
    case (opcode)
      LOAD: begin
        ctrl.reg_w      = {f3, 1'b1};
        ctrl.imm_src    = IMM_I;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_w      = {f3, 1'b0};
        ctrl.result_src = 2'b01;
      end
      STORE: begin
        ctrl.reg_w   = {f3, 1'b0};
        ctrl.imm_src = IMM_S;
        ctrl.alu_src = 1'b1;
        ctrl.mem_w   = {f3, 1'b1};
      end
      R_TYPE: begin
        ctrl.reg_w  = 4'b0101;
        ctrl.alu_op = ALU_FUNCT;
        if (f7 == 7'b0000001) begin
`ifdef DECODE_M_EXT_EN
          ctrl.alu_op = ALU_MULDIV;
`else
          legal = 1'b0;
`endif
        end else if (!((f7 == 7'b0000000) ||
                       (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))) begin
          legal = 1'b0;
        end
      end
      I_TYPE: begin
        ctrl.reg_w   = 4'b0101;
        ctrl.imm_src = shift ? IMM_SHAMT : IMM_I;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_FUNCT;
        // SLLI takes only funct7=0; SRLI/SRAI share f3=101 and differ in bit 30.
        if (shift && !((f7 == 7'b0000000) || (f3 == 3'b101 && f7 == 7'b0100000)))
          legal = 1'b0;
      end
      BRANCH: begin
        ctrl.imm_src = IMM_B;
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALU_BRANCH;
      end
      LUI: begin
        ctrl.reg_w   = 4'b0101;
        ctrl.imm_src = IMM_U;
        ctrl.lui     = 1'b1;
      end
      AUIPC: begin
        ctrl.reg_w   = 4'b0101;
        ctrl.imm_src = IMM_U;
        ctrl.auipc   = 1'b1;
      end
      JAL: begin
        ctrl.reg_w      = 4'b0101;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = 2'b10;
        ctrl.jump       = 1'b1;
      end
      JALR: begin
        ctrl.reg_w      = 4'b0101;
        ctrl.imm_src    = IMM_I;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 2'b10;
        ctrl.jump       = 1'b1;
        ctrl.pc_update  = 1'b1;
        if (f3 != 3'b000) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.ctrl    = legal ? ctrl : '0;
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.pc      = in_pc;
    dec.illegal = !legal;
  end

  decode_fifo #(
    .T     (dec_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (dec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Present zeros when nothing is buffered so reset shows a clean record.
  assign head_view   = empty ? '0 : head;
  assign out_ctrl    = head_view.ctrl;
  assign out_rd      = head_view.rd;
  assign out_rs1     = head_view.rs1;
  assign out_rs2     = head_view.rs2;
  assign out_funct3  = head_view.funct3;
  assign out_funct7  = head_view.funct7;
  assign out_pc      = head_view.pc;
  assign out_illegal = head_view.illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      ill_count <= '0;
    end else if (push && dec.illegal && (ill_count != '1)) begin
      ill_count <= ill_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a random
// stream scored against a queue-based behavioural model.
module tb_decode_stage;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
  localparam int ILL_W = 4;
  localparam int EW    = 79;
`ifdef DECODE_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_instr = '0;
  logic [31:0]       in_pc = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  cntrl_sigs_t       out_ctrl;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [2:0]        out_funct3;
  logic [6:0]        out_funct7;
  logic [31:0]       out_pc;
  logic              out_illegal;
  logic [ILL_W-1:0]  ill_count;

  int               n_checks = 0;
  int               n_pass = 0;
  bit               mon_en = 1'b0;
  bit               stream_done = 1'b0;
  logic [EW-1:0]    exp_q[$];
  logic [ILL_W-1:0] ill_exp = '0;

  decode_stage #(
    .XLEN       (32),
    .FIFO_DEPTH (DEPTH),
    .ILL_CNT_W  (ILL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_pc      (out_pc),
    .out_illegal (out_illegal),
    .ill_count   (ill_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [31:0] instr, input logic [31:0] pc);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] rw, mw;
    logic [2:0] imm;
    logic [1:0] rs, aop;
    logic       asrc, br, j, pcu, lu, au, ok, sh;
    logic [20:0] c;
    op = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
    rw = 0; mw = 0; imm = 0; rs = 0; aop = 0;
    asrc = 0; br = 0; j = 0; pcu = 0; lu = 0; au = 0; ok = 1;
    sh = (f3 == 3'd1) || (f3 == 3'd5);
    case (op)
      7'h03: begin rw = {f3, 1'b1}; asrc = 1; mw = {f3, 1'b0}; rs = 2'd1; end
      7'h23: begin rw = {f3, 1'b0}; imm = 3'd1; asrc = 1; mw = {f3, 1'b1}; end
      7'h33: begin
        rw = 4'd5; aop = (f7 == 7'h01) ? 2'd3 : 2'd2;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
             (M_EN && f7 == 7'h01);
      end
      7'h13: begin
        rw = 4'd5; imm = sh ? 3'd5 : 3'd0; asrc = 1; aop = 2'd2;
        ok = !sh || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
      end
      7'h63: begin imm = 3'd2; br = 1; aop = 2'd1; end
      7'h37: begin rw = 4'd5; imm = 3'd4; lu = 1; end
      7'h17: begin rw = 4'd5; imm = 3'd4; au = 1; end
      7'h6F: begin rw = 4'd5; imm = 3'd3; rs = 2'd2; j = 1; end
      7'h67: begin rw = 4'd5; asrc = 1; rs = 2'd2; j = 1; pcu = 1; ok = (f3 == 3'd0); end
      default: ok = 0;
    endcase
    c = ok ? {rw, imm, asrc, mw, rs, br, aop, j, pcu, lu, au} : 21'd0;
    return {!ok, pc, f7, f3, instr[24:20], instr[19:15], instr[11:7], c};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [10];
    logic [6:0]  op;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
    r  = $urandom();
    op = ops[$urandom_range(0, 9)];
    if (op == 7'h7F) op = r[6:0];
    r[6:0] = op;
    if (op == 7'h33 || op == 7'h13) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (op == 7'h67 && $urandom_range(0, 1) == 0) r[14:12] = 3'd0;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [EW-1:0] e;
      check("in_ready", in_ready, (exp_q.size() < DEPTH) && !flush);
      check("out_valid", out_valid, exp_q.size() != 0);
      check("ill_count", ill_count, ill_exp);
      if (rst) begin
        exp_q.delete();
        ill_exp = '0;
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) begin
          check("head", {out_illegal, out_pc, out_funct7, out_funct3, out_rs2, out_rs1,
                         out_rd, out_ctrl}, exp_q[0]);
          void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
          e = model(in_instr, in_pc);
          exp_q.push_back(e);
          if (e[EW-1] && ill_exp != '1) ill_exp = ill_exp + 1'b1;
        end
        if (flush) exp_q.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    int waited;
    waited   = 0;
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pc;
    int          waited;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ctrl", out_ctrl, 21'd0);
    check("rst_out_illegal", out_illegal, 1'b0);
    check("rst_ill_count", ill_count, 4'd0);
    check("rst_in_ready", in_ready, 1'b1);
    sync();

    // addi x1,x0,5
    out_ready = 1'b1;
    send(32'h00500093, 32'h100);
    @(negedge clk);
    check("addi_valid", out_valid, 1'b1);
    check("addi_reg_w", out_ctrl.reg_w, 4'b0101);
    check("addi_alu_src", out_ctrl.alu_src, 1'b1);
    check("addi_alu_op", out_ctrl.alu_op, 2'b10);
    check("addi_rd", out_rd, 5'd1);
    sync();

    // back-pressure: third instruction held until a pop frees a slot
    out_ready = 1'b0;
    send(32'h00100113, 32'h200);
    send(32'h00200193, 32'h204);
    @(negedge clk);
    check("full_in_ready", in_ready, 1'b0);
    sync();
    fork
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      send(32'h00300213, 32'h208);
    join
    repeat (4) sync();

    // illegal opcode and counter saturation
    send(32'h0000007F, 32'h300);
    @(negedge clk);
    check("ill_flag", out_illegal, 1'b1);
    check("ill_ctrl", out_ctrl, 21'd0);
    check("ill_cnt1", ill_count, 4'd1);
    sync();
    for (int i = 0; i < (1 << ILL_W) + 2; i++) send({$urandom_range(0, 255), 24'h00007F}, 32'h304 + 4 * i);
    repeat (3) sync();
    check("ill_sat", ill_count, 4'hF);

    // flush with two entries buffered
    out_ready = 1'b0;
    send(32'h00000013, 32'h400);
    send(32'h00000033, 32'h404);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    check("flush_valid_before", out_valid, 1'b1);
    sync();
    flush = 1'b0;
    @(negedge clk);
    check("flush_valid_after", out_valid, 1'b0);
    sync();
    out_ready = 1'b1;
    send(32'h008000EF, 32'h500);
    @(negedge clk);
    check("jal_imm_src", out_ctrl.imm_src, 3'b011);
    check("jal_jump", out_ctrl.jump, 1'b1);
    sync();

    // mul x3,x1,x2
    send(32'h022081B3, 32'h600);
    @(negedge clk);
    check("mul_illegal", out_illegal, !M_EN);
    check("mul_alu_op", out_ctrl.alu_op, M_EN ? 2'b11 : 2'b00);
    sync();

    // mid-stream reset drops entries and clears the counter
    out_ready = 1'b0;
    send(32'h0000007F, 32'h700);
    send(32'h00000013, 32'h704);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_ill_count", ill_count, 4'd0);
    sync();

    // random stream with random back-pressure
    pc = 32'h1000;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rand_instr(), pc);
          pc = pc + 4;
          if ($urandom_range(0, 3) == 0) sync();
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    waited = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("drain_empty", exp_q.size(), 0);
    sync();
    @(negedge clk);
    check("drain_valid", out_valid, 1'b0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction-decode stage that replaces the purely combinational opcode decoder between fetch and execute. It accepts one instruction and PC per valid/ready transfer and decodes it into the shared `cntrl_sigs_t` record plus register fields. Results are buffered in a small in-order FIFO, with pipeline flush and illegal-instruction detection. A saturating counter tracks illegal instructions.

## Interface
Parameters:
- `XLEN`, 32, PC width.
- `FIFO_DEPTH`, 2, output buffer entries; power of two, ≥2.
- `ILL_CNT_W`, 16, illegal-instruction counter width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept; equals `!full && !flush`.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  XLEN  instruction PC.
- `flush`  in  1  discard all buffered and incoming entries.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  execute consumes the head.
- `out_ctrl`  out  `cntrl_sigs_t`  decoded control record.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices.
- `out_funct3`  out  3  instruction funct3.
- `out_funct7`  out  7  instruction funct7.
- `out_pc`  out  XLEN  PC of the head entry.
- `out_illegal`  out  1  head entry is an illegal instruction.
- `ill_count`  out  ILL_CNT_W  saturating count of accepted illegal instructions.

## Operation
- Accept when `in_valid && in_ready`. Decode combinationally from `in_instr` and push the record into the FIFO at that edge.
- Pop when `out_valid && out_ready`.
- Decode table. Fields: `reg_w` / `imm_src` / `alu_src` / `mem_w` / `result_src` / `branch` / `alu_op` / `jump` / `pc_update` / `lui` / `auipc`. Any field not listed is 0.
  - LOAD 0000011: {f3,1} / 000 / 1 / {f3,0} / 01 / 0 / 00.
  - STORE 0100011: {f3,0} / 001 / 1 / {f3,1} / 00 / 0 / 00.
  - R 0110011: {010,1} / 000 / 0 / 0 / 00 / 0 / 10.
  - I 0010011: {010,1} / (f3 = 001 or 101 ? 101 : 000) / 1 / 0 / 00 / 0 / 10.
  - BRANCH 1100011: 0 / 010 / 0 / 0 / 00 / 1 / 01.
  - LUI 0110111: {010,1} / 100, `lui`=1.
  - AUIPC 0010111: {010,1} / 100, `auipc`=1.
  - JAL 1101111: {010,1} / 011, `result_src`=10, `jump`=1.
  - JALR 1100111: {010,1} / 000, `alu_src`=1, `result_src`=10, `jump`=1, `pc_update`=1.
- Illegal conditions:
  - any other opcode;
  - R-type with funct7 other than 0000000, or 0100000 with f3 ∈ {000,101};
  - I-type shift with an invalid funct7;
  - JALR with f3 ≠ 000.
- An illegal entry has `out_ctrl` all-zero and `out_illegal`=1. Its fields and PC are passed through unchanged.
- `ill_count` increments on acceptance of an illegal instruction and saturates at all-ones.
- FIFO occupancy is tracked by read/write pointers one bit wider than log2(FIFO_DEPTH). Pointers wrap modulo 2·FIFO_DEPTH.
- `full` and `empty` are derived from the pointers.

## Timing
- Reset values: `out_valid`=0, `out_illegal`=0, `out_ctrl`=0, pointers=0, `ill_count`=0, `in_ready`=1 after reset deasserts.
- Latency: instruction accepted at edge N gives `out_valid`=1 in the cycle following edge N.
- Throughput: one instruction per cycle while `out_ready`=1.
- `in_ready` depends only on registered state and `flush`. There is no combinational path from `out_ready` to `in_ready`, so a full FIFO blocks input even while a pop occurs.
- Push and pop in the same cycle leave occupancy unchanged.
- `flush`:
  - at the next edge, both pointers are set to 0 and `out_valid`=0;
  - no push occurs, because `in_ready`=0;
  - a pop handshake in the flush cycle is still considered consumed;
  - `ill_count` is unaffected.
- `rst` has priority over `flush`. A mid-stream reset drops all entries and clears `ill_count`.
- While `out_valid`=1 and `out_ready`=0, all out_* signals hold stable.

## Configuration
- `DECODE_M_EXT_EN` defined: R-type with funct7=0000001 is legal and decodes as R-type with `alu_op`=11 (MUL/DIV class).
- Not defined: that encoding is illegal, and `alu_op`=11 is never produced.

## Structure
- `riscv_pkg` holds:
  - `cntrl_sigs_t`;
  - the opcode enum (LOAD, STORE, BRANCH, I_TYPE, R_TYPE, JALR, LUI, AUIPC, JAL);
  - the `imm_src` constants (IMM_I=000, IMM_S=001, IMM_B=010, IMM_J=011, IMM_U=100, IMM_SHAMT=101);
  - the `alu_op` constants.
- The FIFO entry struct `dec_entry_t` (ctrl, rd, rs1, rs2, funct3, funct7, pc, illegal) lives in the package, parametrised by XLEN via the package `XLEN` constant.
- One sub-module, `decode_fifo`, is a generic synchronous FIFO taking a type parameter and a depth. The decode logic stays in `decode_stage`.

## Test plan
- Reset then `addi x1,x0,5` (0x00500093) with `out_ready`=1:
  - `out_valid` is 1 one cycle later;
  - `reg_w`=0101, `alu_src`=1, `alu_op`=10, `out_rd`=1.
- `out_ready`=0 and three back-to-back instructions with FIFO_DEPTH=2: `in_ready` drops after two accepts, and the third is held until a pop.
- Opcode 0x0000007F: `out_illegal`=1, `out_ctrl`=0, `ill_count`=1. Drive 2^ILL_CNT_W+3 illegal instructions: the counter sticks at all-ones.
- Two entries buffered, assert `flush` for one cycle: `out_valid`=0 next cycle and `in_ready`=0 during flush. A subsequent `jal` (0x008000EF) decodes with `imm_src`=011 and `jump`=1.
- `mul x3,x1,x2` (0x022081B3): with `DECODE_M_EXT_EN`, `alu_op`=11 and legal; without the macro, `out_illegal`=1.
- Continuous stream with random `out_ready`: output order and PCs match input order with no loss or duplication across pointer wrap-around.
